// File: rtl/bch_decoder.sv
// BCH(63,51) single-error-correcting decoder.
// A received word is divided by g(x) one bit per cycle to form the syndrome,
// then x^i mod g(x) is stepped for i=0..62 and compared against it. The first
// match locates a single error; a nonzero syndrome with no match means two
// errors, which are flagged but left uncorrected.
module bch_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [62:0] codeword_in,
  input  logic        codeword_valid,
  output logic        ready_out,
  output logic [50:0] data_out,
  output logic        valid_out,
  output logic        err_detected,
  output logic        err_corrected,
  output logic        err_uncorrectable
);

  localparam int          N        = 63;
  localparam int          K        = 51;
  localparam logic [12:0] GEN_POLY = 13'b1010100111001;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SYND   = 2'd1;
  localparam logic [1:0] S_SEARCH = 2'd2;
  localparam logic [1:0] S_OUT    = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [N-1:0] cw_q, cw_d;
  logic [11:0]  rem_q, rem_d;
  logic [11:0]  p_q, p_d;
  logic [5:0]   idx_q, idx_d;
  logic         match_q, match_d;
  logic [5:0]   pos_q, pos_d;
  logic [K-1:0] data_q, data_d;
  logic         vld_q, vld_d;
  logic         det_q, det_d;
  logic         cor_q, cor_d;
  logic         unc_q, unc_d;
  logic [N-1:0] corr;

  assign ready_out         = (state_q == S_IDLE);
  assign data_out          = data_q;
  assign valid_out         = vld_q;
  assign err_detected      = det_q;
  assign err_corrected     = cor_q;
  assign err_uncorrectable = unc_q;

  // Next-state logic for the decode sequence IDLE -> SYND -> SEARCH -> OUT.
  always_comb begin
    state_d = state_q;
    cw_d    = cw_q;
    rem_d   = rem_q;
    p_d     = p_q;
    idx_d   = idx_q;
    match_d = match_q;
    pos_d   = pos_q;
    data_d  = data_q;
    det_d   = det_q;
    cor_d   = cor_q;
    unc_d   = unc_q;
    vld_d   = 1'b0;
    corr    = cw_q;
    case (state_q)
      S_IDLE: begin
        if (codeword_valid) begin
          cw_d    = codeword_in;
          rem_d   = '0;
          idx_d   = 6'd62;
          match_d = 1'b0;
          pos_d   = '0;
          state_d = S_SYND;
        end
      end
      S_SYND: begin
        // rem = (rem * x + bit) mod g(x); the x^12 overflow folds back via g.
        rem_d = {rem_q[10:0], cw_q[idx_q]} ^ (rem_q[11] ? GEN_POLY[11:0] : 12'h000);
        if (idx_q == 6'd0) begin
          p_d     = 12'h001;
          idx_d   = '0;
          state_d = S_SEARCH;
        end else begin
          idx_d = idx_q - 6'd1;
        end
      end
      S_SEARCH: begin
        // p holds x^i mod g(x); a single error at bit i has exactly that syndrome.
        if (rem_q != 12'h000 && !match_q && p_q == rem_q) begin
          match_d = 1'b1;
          pos_d   = idx_q;
        end
        p_d = {p_q[10:0], 1'b0} ^ (p_q[11] ? GEN_POLY[11:0] : 12'h000);
        if (idx_q == 6'd62) state_d = S_OUT;
        else                idx_d   = idx_q + 6'd1;
      end
      default: begin
        corr    = cw_q ^ (match_q ? (63'b1 << pos_q) : '0);
        cw_d    = corr;
        data_d  = corr[62:12];
        det_d   = (rem_q != 12'h000);
        cor_d   = match_q;
        unc_d   = (rem_q != 12'h000) && !match_q;
        vld_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cw_q    <= '0;
      rem_q   <= '0;
      p_q     <= '0;
      idx_q   <= '0;
      match_q <= 1'b0;
      pos_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      det_q   <= 1'b0;
      cor_q   <= 1'b0;
      unc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
      rem_q   <= rem_d;
      p_q     <= p_d;
      idx_q   <= idx_d;
      match_q <= match_d;
      pos_q   <= pos_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      det_q   <= det_d;
      cor_q   <= cor_d;
      unc_q   <= unc_d;
    end
  end

endmodule

// File: tb/tb_bch_decoder.sv
// Bench for bch_decoder: random codewords with 0/1/2 errors against a
// polynomial-arithmetic reference model.
module tb_bch_decoder;

  localparam logic [62:0] GEN63 = 63'h1539;
  localparam int LAT = 127; // edges from accept edge to the edge that raises valid_out

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [62:0] codeword_in = '0;
  logic        codeword_valid = 1'b0;
  logic        ready_out;
  logic [50:0] data_out;
  logic        valid_out;
  logic        err_detected, err_corrected, err_uncorrectable;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  bch_decoder dut (
    .clk(clk), .rst(rst), .codeword_in(codeword_in), .codeword_valid(codeword_valid),
    .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out),
    .err_detected(err_detected), .err_corrected(err_corrected),
    .err_uncorrectable(err_uncorrectable)
  );

  // v(x) mod g(x) by long division
  function automatic logic [11:0] mod_g(input logic [62:0] v);
    logic [62:0] r;
    r = v;
    for (int b = 62; b >= 12; b--)
      if (r[b]) r = r ^ (GEN63 << (b - 12));
    return r[11:0];
  endfunction

  function automatic logic [62:0] encode(input logic [50:0] d);
    return {d, mod_g({d, 12'h000})};
  endfunction

  function automatic logic [50:0] rnd_data();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[50:0];
  endfunction

  function automatic logic [62:0] make_rx(input int nerr);
    logic [62:0] cw;
    int p0, p1;
    cw = encode(rnd_data());
    p0 = $urandom_range(62, 0);
    p1 = (p0 + $urandom_range(62, 1)) % 63;
    if (nerr >= 1) cw[p0] = ~cw[p0];
    if (nerr >= 2) cw[p1] = ~cw[p1];
    return cw;
  endfunction

  task automatic model(input logic [62:0] rx, output logic [50:0] d,
                       output logic det, output logic cor, output logic unc);
    logic [11:0] syn;
    logic [62:0] fixed;
    syn = mod_g(rx);
    det = (syn != 12'h000);
    cor = 1'b0;
    fixed = rx;
    for (int i = 0; i < 63; i++)
      if (det && !cor && mod_g(63'b1 << i) == syn) begin
        cor = 1'b1;
        fixed[i] = ~fixed[i];
      end
    unc = det && !cor;
    d = fixed[62:12];
  endtask

  // Present one word, return edges to valid_out and the outputs seen then.
  task automatic run_cw(input logic [62:0] cw, output int lat, output logic [50:0] d,
                        output logic det, output logic cor, output logic unc, output logic rdy);
    @(negedge clk);
    codeword_in = cw;
    codeword_valid = 1'b1;
    @(posedge clk);
    #1 codeword_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      if (valid_out) begin
        lat = n;
        break;
      end
    end
    d = data_out; det = err_detected; cor = err_corrected; unc = err_uncorrectable; rdy = ready_out;
    if (lat < 0) $display("FAIL timeout: no valid_out within 300 cycles");
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({ready_out, valid_out, data_out, err_detected, err_corrected, err_uncorrectable} !==
        {1'b1, 1'b0, 51'h0, 3'b000}) begin
      tests_failed++;
      $display("FAIL reset: rdy=%b vld=%b data=%h flags=%b%b%b required rdy=1 vld=0 data=0 flags=000",
               ready_out, valid_out, data_out, err_detected, err_corrected, err_uncorrectable);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_zero();
    int lat; logic [50:0] d; logic det, cor, unc, rdy;
    run_cw(63'h0, lat, d, det, cor, unc, rdy);
    tests_run++;
    if (lat !== LAT) begin
      tests_failed++;
      $display("FAIL zero_latency: got %0d required %0d", lat, LAT);
    end
    tests_run++;
    if ({d, det, cor, unc, rdy} !== {51'h0, 3'b000, 1'b1}) begin
      tests_failed++;
      $display("FAIL zero_out: data=%h flags=%b%b%b rdy=%b required data=0 flags=000 rdy=1",
               d, det, cor, unc, rdy);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (valid_out !== 1'b0 || data_out !== 51'h0) begin
      tests_failed++;
      $display("FAIL zero_pulse: vld=%b data=%h required vld=0 data=0", valid_out, data_out);
    end
  endtask

  task automatic test_bit0();
    int lat; logic [50:0] d; logic det, cor, unc, rdy;
    run_cw(63'h1, lat, d, det, cor, unc, rdy);
    tests_run++;
    if ({d, det, cor, unc} !== {51'h0, 3'b110} || lat !== LAT) begin
      tests_failed++;
      $display("FAIL bit0: data=%h flags=%b%b%b lat=%0d required data=0 flags=110 lat=%0d",
               d, det, cor, unc, lat, LAT);
    end
  endtask

  task automatic test_single_all();
    int lat; logic [50:0] d, orig; logic det, cor, unc, rdy; logic [62:0] rx;
    for (int pos = 62; pos >= 0; pos--) begin
      orig = rnd_data();
      rx = encode(orig);
      rx[pos] = ~rx[pos];
      run_cw(rx, lat, d, det, cor, unc, rdy);
      tests_run++;
      if ({d, det, cor, unc} !== {orig, 3'b110} || lat !== LAT) begin
        tests_failed++;
        $display("FAIL single_pos%0d: data=%h flags=%b%b%b lat=%0d required data=%h flags=110 lat=%0d",
                 pos, d, det, cor, unc, lat, orig, LAT);
      end
    end
  endtask

  task automatic test_double();
    int lat; logic [50:0] d, ed; logic det, cor, unc, rdy, edet, ecor, eunc; logic [62:0] rx;
    run_cw(63'h3, lat, d, det, cor, unc, rdy);
    tests_run++;
    if ({d, det, cor, unc} !== {51'h0, 3'b101}) begin
      tests_failed++;
      $display("FAIL double_h3: data=%h flags=%b%b%b required data=0 flags=101", d, det, cor, unc);
    end
    for (int k = 0; k < 6; k++) begin
      rx = make_rx(2);
      model(rx, ed, edet, ecor, eunc);
      run_cw(rx, lat, d, det, cor, unc, rdy);
      tests_run++;
      if ({d, det, cor, unc} !== {ed, edet, ecor, eunc} || {d, unc} !== {rx[62:12], 1'b1}) begin
        tests_failed++;
        $display("FAIL double_rnd%0d: data=%h flags=%b%b%b required data=%h flags=%b%b%b",
                 k, d, det, cor, unc, ed, edet, ecor, eunc);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [62:0] words [0:383];
    logic [50:0] ed; logic edet, ecor, eunc, ev;
    int pulses;
    for (int t = 0; t < 384; t++) words[t] = make_rx(t % 3);
    pulses = 0;
    @(negedge clk);
    codeword_in = words[0];
    codeword_valid = 1'b1;
    for (int t = 0; t < 384; t++) begin
      @(posedge clk);
      #1;
      ev = ((t % 128) == 127);
      if (valid_out) pulses++;
      tests_run++;
      if (valid_out !== ev || ready_out !== ev) begin
        tests_failed++;
        $display("FAIL b2b_timing t=%0d: vld=%b rdy=%b required vld=%b rdy=%b",
                 t, valid_out, ready_out, ev, ev);
      end
      if (ev) begin
        model(words[t - 127], ed, edet, ecor, eunc);
        tests_run++;
        if ({data_out, err_detected, err_corrected, err_uncorrectable} !== {ed, edet, ecor, eunc}) begin
          tests_failed++;
          $display("FAIL b2b_data t=%0d: data=%h flags=%b%b%b required data=%h flags=%b%b%b",
                   t, data_out, err_detected, err_corrected, err_uncorrectable, ed, edet, ecor, eunc);
        end
      end
      if (t < 383) codeword_in = words[t + 1];
      else codeword_valid = 1'b0;
    end
    tests_run++;
    if (pulses !== 3) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d pulses required 3", pulses);
    end
  endtask

  task automatic test_reset_mid();
    int lat, stray; logic [50:0] d, orig; logic det, cor, unc, rdy; logic [62:0] rx;
    @(negedge clk);
    codeword_in = make_rx(1);
    codeword_valid = 1'b1;
    @(posedge clk);
    #1 codeword_valid = 1'b0;
    repeat (90) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({ready_out, valid_out, data_out, err_detected, err_corrected, err_uncorrectable} !==
        {1'b1, 1'b0, 51'h0, 3'b000}) begin
      tests_failed++;
      $display("FAIL midreset_clear: rdy=%b vld=%b data=%h flags=%b%b%b required rdy=1 vld=0 data=0 flags=000",
               ready_out, valid_out, data_out, err_detected, err_corrected, err_uncorrectable);
    end
    @(negedge clk);
    rst = 1'b1;
    stray = 0;
    repeat (140) begin
      @(posedge clk);
      #1;
      if (valid_out) stray++;
    end
    tests_run++;
    if (stray !== 0) begin
      tests_failed++;
      $display("FAIL midreset_stray: got %0d valid_out pulses required 0", stray);
    end
    orig = rnd_data();
    rx = encode(orig);
    rx[17] = ~rx[17];
    run_cw(rx, lat, d, det, cor, unc, rdy);
    tests_run++;
    if ({d, det, cor, unc} !== {orig, 3'b110} || lat !== LAT) begin
      tests_failed++;
      $display("FAIL midreset_next: data=%h flags=%b%b%b lat=%0d required data=%h flags=110 lat=%0d",
               d, det, cor, unc, lat, orig, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_bit0();
    test_single_all();
    test_double();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bch_decoder.md
Name: bch_decoder

Overview:
- Downstream stage of the BCH(63,51) encoder. It takes one parallel 63-bit received codeword per transaction.
- It computes the syndrome (remainder modulo g(x)) serially, then runs a 63-step Chien/Meggitt-style search to correct one error.
- It outputs the 51 corrected data bits with error status.
- Two-error patterns are detected and flagged as uncorrectable; the data is not corrected in that case.

Parameters:
- N, 63, codeword length in bits (fixed; not a supported override)
- K, 51, data bits per codeword (fixed)
- GEN_POLY, 13'b1010100111001, generator g(x)=x^12+x^10+x^8+x^5+x^4+x^3+1

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- codeword_in  input  63  received codeword
  - bit 62 = first data bit
  - bits 62:12 = data, bits 11:0 = parity (coefficient of x^k at bit k)
- codeword_valid  input  1  codeword_in is valid; accepted when codeword_valid && ready_out at a rising edge
- ready_out  output  1  decoder idle and able to accept a codeword
- data_out  output  51  corrected data, equal to corrected codeword bits 62:12
- valid_out  output  1  one-cycle pulse; data_out and the flags are valid while high
- err_detected  output  1  syndrome was nonzero
- err_corrected  output  1  single error found and flipped
- err_uncorrectable  output  1  syndrome nonzero and no single-error match found

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, ready_out=1, valid_out=0, data_out=0, all err_* flags=0, internal registers cleared.
  - Reset asserted mid-operation aborts the codeword. No valid_out is produced for it.
- States: IDLE -> SYND -> SEARCH -> OUT -> IDLE.
- IDLE:
  - ready_out=1.
  - On the accept edge: latch codeword_in into cw_reg, clear rem[11:0], set bit index to 62, go to SYND, drop ready_out.
  - codeword_valid while ready_out=0 is ignored. There is no queue, so upstream must hold or drop the codeword.
- SYND: 63 cycles. Each edge processes cw_reg bit idx, from 62 down to 0:
  - fb = rem[11]
  - rem = {rem[10:0], bit} ^ (fb ? GEN_POLY[11:0] : 0)
  - After bit 0, rem = c(x) mod g(x). Go to SEARCH with p=12'h001 and i=0.
- SEARCH: 63 cycles, i=0..62, fixed length regardless of result.
  - If rem!=0 and p==rem (first match only): set match=1 and store pos=i.
  - Update p = (p<<1) ^ (p[11] ? GEN_POLY[11:0] : 0), keeping 12 bits.
  - After i=62, go to OUT.
- OUT: one cycle.
  - If match, flip cw_reg[pos].
  - data_out <= corrected[62:12].
  - err_detected <= (rem!=0).
  - err_corrected <= match.
  - err_uncorrectable <= (rem!=0) && !match.
  - valid_out pulses high for exactly one cycle. Next state is IDLE.
- Output holding:
  - data_out and the flags are registered and hold their values until the next OUT.
  - valid_out is 0 outside OUT.
- Latency:
  - Codeword accepted at edge E means valid_out is high in the cycle after edge E+127 (1+63+63 edges, plus the OUT register).
  - ready_out returns high in the same cycle valid_out is high. A new codeword may therefore be accepted at edge E+128, for a throughput of 128 cycles per codeword.
- Error-pattern guarantees (minimum distance 5):
  - A single error at bit i always matches at step i.
  - Two errors never match, so they always flag err_uncorrectable.
  - Three or more errors are undefined, possibly a miscorrection.
- All-zero syndrome: no flip, err_detected=0, data_out = cw[62:12].

Test Plan:
- Reset, then all-zero codeword -> after 128 cycles valid_out=1 for one cycle, data_out=0, all flags 0, ready_out=1.
- Zero codeword with bit 0 flipped (63'h1) -> syndrome 12'h001, match at i=0, data_out=0, err_detected=1, err_corrected=1.
- Encoder loopback: random 51-bit data through bch_encoder, then flip bit 62 -> data_out equals the original data (bit 50 restored), err_corrected=1. Repeat for every bit position 0..62.
- Zero codeword with bits 0 and 1 flipped (63'h3) -> syndrome 12'h003, err_detected=1, err_corrected=0, err_uncorrectable=1, data_out=0.
- codeword_valid held high continuously -> acceptances exactly 128 cycles apart. Codewords presented while ready_out=0 are not captured, and one valid_out per accepted codeword.
- rst pulsed low during SEARCH -> outputs clear immediately, no valid_out for the aborted word. The next codeword decodes correctly with the standard 128-cycle latency.
